// File: rtl/serial_out.sv
// Serial transmitter: streams the active field of each dataset row LSB-first,
// one bit per clock, prefetching the next row so rows follow with no gap.
module serial_out #(
   parameter int ADDR_WIDTH   = 12,
   parameter int MAX_FEATURES = 15,
   parameter int LENGTH       = 16,
   parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] num_dp,
   input  logic [3:0]            feat,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  ser,
   output logic                  ser_valid,
   output logic                  busy,
   output logic                  flag,
   output logic                  done
);

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ROW_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

   state_t                  state, state_n;
   logic                    rd_en_n;
   logic [ADDR_WIDTH-1:0]   rd_addr_n;
   logic                    ser_n, ser_valid_n, busy_n, flag_n, done_n;
   logic [DATA_WIDTH-1:0]   shift_reg, shift_n;
   logic [DATA_WIDTH-1:0]   next_buf, next_buf_n;
   logic [IDX_W-1:0]        idx, idx_n, idx_inc;
   logic [ADDR_WIDTH-1:0]   row, row_n;
   logic [ADDR_WIDTH-1:0]   num_q, num_n;
   logic [3:0]              feat_q, feat_n;
   logic                    rd_vld_p1;
   logic [IDX_W-1:0]        init_w, mid_w;

   // First transmitted bit of a row: everything below it is unused field space.
   function automatic logic [IDX_W-1:0] init_of(input logic [3:0] f);
      logic [IDX_W:0] span;
      span = (IDX_W+1)'(LENGTH) * ((IDX_W+1)'(f) + (IDX_W+1)'(1));
      return IDX_W'((IDX_W+1)'(DATA_WIDTH) - span);
   endfunction

   function automatic logic [IDX_W-1:0] mid_of(input logic [3:0] f);
      return init_of(f) + IDX_W'(LENGTH / 2) * IDX_W'(f);
   endfunction

   assign init_w  = init_of(feat_q);
   assign mid_w   = mid_of(feat_q);
   assign idx_inc = idx + IDX_ONE;

   always_comb begin
      state_n     = state;
      rd_en_n     = 1'b0;
      rd_addr_n   = rd_addr;
      ser_n       = 1'b0;
      ser_valid_n = 1'b0;
      busy_n      = 1'b0;
      flag_n      = flag;
      done_n      = done;
      shift_n     = shift_reg;
      next_buf_n  = rd_vld_p1 ? rd_data : next_buf;
      idx_n       = idx;
      row_n       = row;
      feat_n      = feat_q;
      num_n       = num_q;

      case (state)
         IDLE: begin
            if (start) begin
               state_n   = FETCH;
               rd_en_n   = 1'b1;
               rd_addr_n = '0;
               busy_n    = 1'b1;
               feat_n    = feat;
               num_n     = num_dp;
            end
         end
         FETCH: begin
            state_n = LOAD;
            busy_n  = 1'b1;
         end
         LOAD: begin
            state_n     = SHIFT;
            busy_n      = 1'b1;
            shift_n     = rd_data;
            idx_n       = init_w;
            row_n       = '0;
            ser_n       = rd_data[init_w];
            ser_valid_n = 1'b1;
         end
         SHIFT: begin
            busy_n      = 1'b1;
            ser_valid_n = 1'b1;
            // Fetch the following row at the start of this one; even a 16-bit
            // row outlasts the two-cycle RAM latency.
            if (idx == init_w && row < num_q) begin
               rd_en_n   = 1'b1;
               rd_addr_n = row + ROW_ONE;
            end
            if (idx == LAST_IDX) begin
               if (row == num_q) begin
                  state_n     = DONE;
                  ser_valid_n = 1'b0;
                  busy_n      = 1'b0;
                  done_n      = 1'b1;
               end else begin
                  shift_n = next_buf;
                  idx_n   = init_w;
                  row_n   = row + ROW_ONE;
                  ser_n   = next_buf[init_w];
               end
            end else begin
               idx_n = idx_inc;
               ser_n = shift_reg[idx_inc];
            end
         end
         DONE: begin
            state_n = DONE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (ser_valid_n && row_n == num_n && idx_n == mid_w)
         flag_n = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         ser       <= 1'b0;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         flag      <= 1'b0;
         done      <= 1'b0;
         shift_reg <= '0;
         next_buf  <= '0;
         idx       <= '0;
         row       <= '0;
         num_q     <= '0;
         feat_q    <= '0;
         rd_vld_p1 <= 1'b0;
      end else begin
         state     <= state_n;
         rd_en     <= rd_en_n;
         rd_addr   <= rd_addr_n;
         ser       <= ser_n;
         ser_valid <= ser_valid_n;
         busy      <= busy_n;
         flag      <= flag_n;
         done      <= done_n;
         shift_reg <= shift_n;
         next_buf  <= next_buf_n;
         idx       <= idx_n;
         row       <= row_n;
         num_q     <= num_n;
         feat_q    <= feat_n;
         // RAM data for a read strobe is capturable one cycle after this stage
         rd_vld_p1 <= rd_en;
      end
   end

endmodule

// File: tb/tb_serial_out.sv
// Bench for serial_out: row RAM model, output monitor, and a scoreboard of
// expected serial bits built from the RAM contents at start time.
module tb_serial_out;

   localparam int AW = 12;
   localparam int DW = 256;

   logic          CLK = 1'b0;
   logic          RST;
   logic          start;
   logic [AW-1:0] num_dp;
   logic [3:0]    feat;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          ser, ser_valid, busy, flag, done;

   logic [DW-1:0] mem [0:7];
   bit            exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;

   int            cyc = 0;
   int            obs_n = 0;
   bit            obs_bit  [0:4095];
   bit            obs_flag [0:4095];
   int            rd_n = 0;
   logic [AW-1:0] rd_log [0:63];
   int            seg_n = 0;
   int            seg_cyc = 0;
   bit            prev_v = 1'b0;
   bit            end_done = 1'b0;
   int            stray_ser = 0;

   serial_out dut (
      .CLK(CLK), .RST(RST), .start(start), .num_dp(num_dp), .feat(feat),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .ser(ser), .ser_valid(ser_valid), .busy(busy), .flag(flag), .done(done)
   );

   always #5 CLK = ~CLK;

   // synchronous-read row RAM
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (rd_en === 1'b1) rd_data <= mem[rd_addr[2:0]];
   end

   // monitor: record what the DUT emits, away from the active edge
   always @(negedge CLK) begin
      prev_v <= (ser_valid === 1'b1);
      if (ser_valid === 1'b1) begin
         if (obs_n < 4096) begin
            obs_bit[obs_n]  <= ser;
            obs_flag[obs_n] <= flag;
         end
         obs_n <= obs_n + 1;
         if (!prev_v) begin
            seg_n   <= seg_n + 1;
            seg_cyc <= cyc;
         end
      end else begin
         if (ser === 1'b1) stray_ser <= stray_ser + 1;
         if (prev_v) end_done <= done;
      end
      if (rd_en === 1'b1) begin
         if (rd_n < 64) rd_log[rd_n] <= rd_addr;
         rd_n <= rd_n + 1;
      end
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      start = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] f, input logic [AW-1:0] n, output int c0);
      feat = f;
      num_dp = n;
      start = 1'b1;
      c0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done === 1'b1) begin
            timeout = 1'b0;
            break;
         end
         tick();
      end
   endtask

   function automatic logic [DW-1:0] rand_row();
      logic [DW-1:0] r;
      for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // reference model: a row contributes bits DW-16*(f+1) .. DW-1, ascending
   task automatic push_rows(input int nrows, input logic [3:0] f);
      int first;
      first = DW - 16 * (int'(f) + 1);
      for (int r = 0; r < nrows; r++)
         for (int b = first; b < DW; b++) exp_q.push_back(mem[r][b]);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      start = 1'b0;
      feat = '0;
      num_dp = '0;
      tick();
      tick();
      tick();
      n_cmp++;
      if ({rd_en, rd_addr, ser, ser_valid, busy, flag, done} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {rd_en, rd_addr, ser, ser_valid, busy, flag, done});
      end
      RST = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({rd_en, busy, ser_valid, done} !== 4'b0000) begin
         n_bad++;
         $display("FAIL idle_hold: got %b want 0000", {rd_en, busy, ser_valid, done});
      end
   endtask

   task automatic test_single_row();
      int base, rb, sb, c0, len;
      bit to, b;
      logic [15:0] got;
      apply_reset();
      mem[0] = rand_row();
      mem[0][255:240] = 16'hABCD;
      exp_q.delete();
      push_rows(1, 4'd0);
      len = exp_q.size();
      base = obs_n; rb = rd_n; sb = seg_n;
      pulse_start(4'd0, 12'd0, c0);
      wait_done(200, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL single_done: got timeout want done"); end
      n_cmp++;
      if (obs_n - base != len) begin
         n_bad++; $display("FAIL single_len: got %0d want %0d", obs_n - base, len);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_cmp++;
         if (obs_bit[base + i] !== b) begin
            n_bad++; $display("FAIL single_bit[%0d]: got %b want %b", i, obs_bit[base + i], b);
         end
      end
      for (int i = 0; i < 16; i++) got[i] = obs_bit[base + i];
      n_cmp++;
      if (got !== 16'hABCD) begin n_bad++; $display("FAIL single_word: got %h want abcd", got); end
      n_cmp++;
      if (rd_n - rb != 1 || rd_log[rb] !== 12'd0) begin
         n_bad++; $display("FAIL single_reads: got %0d reads addr %0d want 1 read addr 0", rd_n - rb, rd_log[rb]);
      end
      n_cmp++;
      if (seg_cyc != c0 + 3 || seg_n - sb != 1) begin
         n_bad++; $display("FAIL single_latency: got edge %0d segs %0d want edge %0d segs 1", seg_cyc - c0, seg_n - sb, 3);
      end
      n_cmp++;
      if (obs_flag[base] !== 1'b1) begin n_bad++; $display("FAIL single_flag: got %b want 1", obs_flag[base]); end
      n_cmp++;
      if (end_done !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL single_end: got done=%b busy=%b want done=1 busy=0", end_done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int base, rb, sb, c0, len, st;
      bit to, b;
      apply_reset();
      for (int r = 0; r < 3; r++) mem[r] = rand_row();
      exp_q.delete();
      push_rows(3, 4'd15);
      len = exp_q.size();
      base = obs_n; rb = rd_n; sb = seg_n; st = stray_ser;
      pulse_start(4'd15, 12'd2, c0);
      wait_done(1200, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL b2b_done: got timeout want done"); end
      n_cmp++;
      if (obs_n - base != len) begin
         n_bad++; $display("FAIL b2b_len: got %0d want %0d", obs_n - base, len);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_cmp++;
         if (obs_bit[base + i] !== b) begin
            n_bad++; $display("FAIL b2b_bit[%0d]: got %b want %b", i, obs_bit[base + i], b);
         end
      end
      n_cmp++;
      if (rd_n - rb != 3) begin n_bad++; $display("FAIL b2b_nreads: got %0d want 3", rd_n - rb); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (rd_log[rb + k] !== AW'(k)) begin
            n_bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, rd_log[rb + k], k);
         end
      end
      n_cmp++;
      if (seg_n - sb != 1) begin n_bad++; $display("FAIL b2b_contiguous: got %0d segments want 1", seg_n - sb); end
      n_cmp++;
      if (stray_ser != st || end_done !== 1'b1) begin
         n_bad++; $display("FAIL b2b_end: got stray=%0d done=%b want stray=0 done=1", stray_ser - st, end_done);
      end
   endtask

   task automatic test_flag_timing();
      int base, c0, len, first, ones;
      bit to, b;
      apply_reset();
      for (int r = 0; r < 2; r++) mem[r] = rand_row();
      exp_q.delete();
      push_rows(2, 4'd3);
      len = exp_q.size();
      base = obs_n;
      pulse_start(4'd3, 12'd1, c0);
      wait_done(400, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL flag_done: got timeout want done"); end
      n_cmp++;
      if (obs_n - base != len) begin
         n_bad++; $display("FAIL flag_len: got %0d want %0d", obs_n - base, len);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_cmp++;
         if (obs_bit[base + i] !== b) begin
            n_bad++; $display("FAIL flag_bit[%0d]: got %b want %b", i, obs_bit[base + i], b);
         end
      end
      first = -1; ones = 0;
      for (int i = 0; i < len; i++) begin
         if (obs_flag[base + i] === 1'b1) begin
            ones++;
            if (first < 0) first = i;
         end
      end
      // row 0 is 64 bits; row 1 bit 216 is its 25th bit
      n_cmp++;
      if (first != 88) begin n_bad++; $display("FAIL flag_rise: got pos %0d want 88", first); end
      n_cmp++;
      if (ones != 40) begin n_bad++; $display("FAIL flag_sticky: got %0d flagged bits want 40", ones); end
      n_cmp++;
      if (end_done !== 1'b1 || flag !== 1'b1) begin
         n_bad++; $display("FAIL flag_end: got done=%b flag=%b want 1 1", end_done, flag);
      end
   endtask

   task automatic test_reset_mid();
      int base, rb, c0, len;
      bit to, b;
      apply_reset();
      for (int r = 0; r < 2; r++) mem[r] = rand_row();
      base = obs_n;
      pulse_start(4'd15, 12'd1, c0);
      to = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (obs_n - base >= 457) begin to = 1'b0; break; end
         tick();
      end
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL mid_reach: got %0d bits want 457", obs_n - base); end
      n_cmp++;
      if (flag !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL mid_before: got flag=%b busy=%b want 1 1", flag, busy);
      end
      RST = 1'b1;
      tick();
      n_cmp++;
      if ({rd_en, rd_addr, ser, ser_valid, busy, flag, done} !== '0) begin
         n_bad++; $display("FAIL mid_reset: got %b want all zero",
                           {rd_en, rd_addr, ser, ser_valid, busy, flag, done});
      end
      RST = 1'b0;
      tick();
      mem[0] = rand_row();
      exp_q.delete();
      push_rows(1, 4'd1);
      len = exp_q.size();
      base = obs_n; rb = rd_n;
      pulse_start(4'd1, 12'd0, c0);
      wait_done(200, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL mid_again_done: got timeout want done"); end
      n_cmp++;
      if (obs_n - base != len) begin
         n_bad++; $display("FAIL mid_again_len: got %0d want %0d", obs_n - base, len);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_cmp++;
         if (obs_bit[base + i] !== b) begin
            n_bad++; $display("FAIL mid_again_bit[%0d]: got %b want %b", i, obs_bit[base + i], b);
         end
      end
      n_cmp++;
      if (rd_n - rb != 1 || rd_log[rb] !== 12'd0) begin
         n_bad++; $display("FAIL mid_again_reads: got %0d reads addr %0d want 1 read addr 0", rd_n - rb, rd_log[rb]);
      end
   endtask

   task automatic test_ignored_inputs();
      int base, rb, sb, c0, len, rd_at_done;
      bit to, b;
      apply_reset();
      for (int r = 0; r < 2; r++) mem[r] = rand_row();
      exp_q.delete();
      push_rows(2, 4'd2);
      len = exp_q.size();
      base = obs_n; rb = rd_n; sb = seg_n;
      pulse_start(4'd2, 12'd1, c0);
      for (int i = 0; i < 100; i++) begin
         if (obs_n - base >= 10) break;
         tick();
      end
      start = 1'b1;
      feat = 4'd15;
      num_dp = 12'd5;
      for (int i = 0; i < 4; i++) tick();
      start = 1'b0;
      wait_done(400, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL ign_done: got timeout want done"); end
      rd_at_done = rd_n;
      start = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      start = 1'b0;
      tick();
      n_cmp++;
      if ({done, busy, ser_valid, rd_en} !== 4'b1000 || rd_n != rd_at_done) begin
         n_bad++; $display("FAIL ign_done_hold: got done/busy/vld/rd=%b extra reads %0d want 1000 and 0",
                           {done, busy, ser_valid, rd_en}, rd_n - rd_at_done);
      end
      n_cmp++;
      if (obs_n - base != len) begin
         n_bad++; $display("FAIL ign_len: got %0d want %0d", obs_n - base, len);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_cmp++;
         if (obs_bit[base + i] !== b) begin
            n_bad++; $display("FAIL ign_bit[%0d]: got %b want %b", i, obs_bit[base + i], b);
         end
      end
      n_cmp++;
      if (rd_n - rb != 2 || rd_log[rb] !== 12'd0 || rd_log[rb + 1] !== 12'd1) begin
         n_bad++; $display("FAIL ign_reads: got %0d reads (%0d,%0d) want 2 reads (0,1)",
                           rd_n - rb, rd_log[rb], rd_log[rb + 1]);
      end
      n_cmp++;
      if (seg_n - sb != 1) begin n_bad++; $display("FAIL ign_contiguous: got %0d segments want 1", seg_n - sb); end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || flag !== 1'b0) begin
         n_bad++; $display("FAIL ign_clear: got done=%b flag=%b want 0 0", done, flag);
      end
   endtask

   initial begin
      RST = 1'b1;
      start = 1'b0;
      feat = '0;
      num_dp = '0;
      test_reset();
      test_single_row();
      test_back_to_back();
      test_flag_timing();
      test_reset_mid();
      test_ignored_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
